// File: rtl/sub_pkg.sv
// sub_pkg: shared FSM state encoding and default operand width for serial_sub.
package sub_pkg;
  localparam int DEFAULT_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/operand request and result bundle of the serial subtractor.
interface serial_sub_if
  import sub_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zr;
  logic             ng;
  modport master (output start, a, b, input ready, done, diff, borrow, zr, ng);
  modport slave  (input start, a, b, output ready, done, diff, borrow, zr, ng);
endinterface

// File: rtl/half_subtractor.sv
// half_subtractor: one-bit x minus y producing difference and borrow.
module half_subtractor (
  input  logic x_i,
  input  logic y_i,
  output logic d_o,
  output logic b_o
);
  assign d_o = x_i ^ y_i;
  assign b_o = ~x_i & y_i;
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first subtractor, one bit per clock, WIDTH-cycle latency.
module serial_sub
  import sub_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic         clk,
  input  logic         reset,
  serial_sub_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d, borrow_q, borrow_d, zr_q, zr_d, ng_q, ng_d;
  logic             d1, b1, d, b2, bout;
  // full-subtract bit built from two half subtractors: (x - y) - bin
  half_subtractor u_hs0 (.x_i(a_q[0]), .y_i(b_q[0]), .d_o(d1), .b_o(b1));
  half_subtractor u_hs1 (.x_i(d1), .y_i(bin_q), .d_o(d), .b_o(b2));
  assign bout = b1 | b2;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d     = bus.a;
        b_d     = bus.b;
        bin_d   = 1'b0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {d, r_q[WIDTH-1:1]};
        bin_d = bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = r_d;
          borrow_d = bout;
          zr_d     = ~|r_d;
          ng_d     = d;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zr_q     <= 1'b1;
      ng_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
    end
  end
  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.zr     = zr_q;
  assign bus.ng     = ng_q;
endmodule
